// File: rtl/frame_scan_pkg.sv
// Shared defaults, scan state encoding and the centroid sum width for the frame blob scanner.
// Sums are wide enough for every x (or y) of a full 640x480 frame being white.
package frame_scan_pkg;
    localparam int H_RES_DEF      = 640;
    localparam int V_RES_DEF      = 480;
    localparam int ADDR_W_DEF     = 19;
    localparam int COORD_W_DEF    = 10;
    localparam int MIN_PIXELS_DEF = 64;
    localparam int SUM_W          = 28;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } scan_state_t;
endpackage

// File: rtl/bbox_accum.sv
// Working min/max/count accumulator for white pixels (plus x/y sums when CENTROID_EN is defined).
// Updates one cycle after an enabled white pixel; clear reloads the empty-box values.
module bbox_accum
    import frame_scan_pkg::*;
#(
    parameter int COORD_W = COORD_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_clear,
    input  logic               i_en,
    input  logic               i_pixel,
    input  logic [COORD_W-1:0] i_x,
    input  logic [COORD_W-1:0] i_y,
    output logic [COORD_W-1:0] o_xmin,
    output logic [COORD_W-1:0] o_xmax,
    output logic [COORD_W-1:0] o_ymin,
    output logic [COORD_W-1:0] o_ymax,
    output logic [ADDR_W-1:0]  o_count
`ifdef CENTROID_EN
    ,
    output logic [SUM_W-1:0]   o_sumx,
    output logic [SUM_W-1:0]   o_sumy
`endif
);
    logic [COORD_W-1:0] r_xmin, r_xmax, r_ymin, r_ymax;
    logic [ADDR_W-1:0]  r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n || i_clear) begin
            r_xmin  <= '1;
            r_xmax  <= '0;
            r_ymin  <= '1;
            r_ymax  <= '0;
            r_count <= '0;
        end else if (i_en && i_pixel) begin
            if (i_x < r_xmin) r_xmin <= i_x;
            if (i_x > r_xmax) r_xmax <= i_x;
            if (i_y < r_ymin) r_ymin <= i_y;
            if (i_y > r_ymax) r_ymax <= i_y;
            r_count <= r_count + ADDR_W'(1);
        end
    end

    assign o_xmin  = r_xmin;
    assign o_xmax  = r_xmax;
    assign o_ymin  = r_ymin;
    assign o_ymax  = r_ymax;
    assign o_count = r_count;

`ifdef CENTROID_EN
    logic [SUM_W-1:0] r_sumx, r_sumy;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n || i_clear) begin
            r_sumx <= '0;
            r_sumy <= '0;
        end else if (i_en && i_pixel) begin
            r_sumx <= r_sumx + SUM_W'(i_x);
            r_sumy <= r_sumy + SUM_W'(i_y);
        end
    end

    assign o_sumx = r_sumx;
    assign o_sumy = r_sumy;
`endif
endmodule

// File: rtl/frame_blob_scanner.sv
// Scans the idle capture buffer once per Start and publishes the white-pixel bounding box and count.
// Start -> Done is H_RES*V_RES+2 cycles; Start is ignored while busy; CENTROID_EN adds SumX/SumY.
module frame_blob_scanner
    import frame_scan_pkg::*;
#(
    parameter int H_RES      = H_RES_DEF,
    parameter int V_RES      = V_RES_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int COORD_W    = COORD_W_DEF,
    parameter int MIN_PIXELS = MIN_PIXELS_DEF
) (
    input  logic               PCLK,
    input  logic               Reset_n,
    input  logic               Start,
    output logic [ADDR_W-1:0]  ReadAddr,
    input  logic               BufferData,
    output logic               Busy,
    output logic               Done,
    output logic               ObjValid,
    output logic [COORD_W-1:0] XMin,
    output logic [COORD_W-1:0] XMax,
    output logic [COORD_W-1:0] YMin,
    output logic [COORD_W-1:0] YMax,
    output logic [ADDR_W-1:0]  PixelCount
`ifdef CENTROID_EN
    ,
    output logic [SUM_W-1:0]   SumX,
    output logic [SUM_W-1:0]   SumY
`endif
);
    localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);
    localparam logic [COORD_W-1:0] LAST_X    = COORD_W'(H_RES - 1);

    scan_state_t        r_state, w_state_nxt;
    logic [ADDR_W-1:0]  r_addr;
    logic [COORD_W-1:0] r_x, r_y, r_px_x, r_px_y;
    logic               r_px_vld;
    logic [COORD_W-1:0] w_xmin, w_xmax, w_ymin, w_ymax;
    logic [ADDR_W-1:0]  w_count;

    always_ff @(posedge PCLK or negedge Reset_n) begin
        if (!Reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (Start) w_state_nxt = ST_SCAN;
            ST_SCAN:  if (r_addr == LAST_ADDR) w_state_nxt = ST_DRAIN;
            ST_DRAIN: w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Address and coordinates advance together so no y*H_RES product is ever needed.
    always_ff @(posedge PCLK or negedge Reset_n) begin
        if (!Reset_n) begin
            r_addr <= '0;
            r_x    <= '0;
            r_y    <= '0;
        end else if (r_state == ST_SCAN && r_addr != LAST_ADDR) begin
            r_addr <= r_addr + ADDR_W'(1);
            if (r_x == LAST_X) begin
                r_x <= '0;
                r_y <= r_y + COORD_W'(1);
            end else begin
                r_x <= r_x + COORD_W'(1);
            end
        end else if (r_state == ST_DONE) begin
            r_addr <= '0;
            r_x    <= '0;
            r_y    <= '0;
        end
    end

    always_ff @(posedge PCLK or negedge Reset_n) begin
        if (!Reset_n) begin
            r_px_vld <= 1'b0;
            r_px_x   <= '0;
            r_px_y   <= '0;
        end else begin
            r_px_vld <= (r_state == ST_SCAN);
            r_px_x   <= r_x;
            r_px_y   <= r_y;
        end
    end

`ifdef CENTROID_EN
    logic [SUM_W-1:0] w_sumx, w_sumy;
`endif

    bbox_accum #(.COORD_W(COORD_W), .ADDR_W(ADDR_W)) u_accum (
        .i_clk   (PCLK),
        .i_rst_n (Reset_n),
        .i_clear (r_state == ST_IDLE),
        .i_en    (r_px_vld),
        .i_pixel (BufferData),
        .i_x     (r_px_x),
        .i_y     (r_px_y),
        .o_xmin  (w_xmin),
        .o_xmax  (w_xmax),
        .o_ymin  (w_ymin),
        .o_ymax  (w_ymax),
        .o_count (w_count)
`ifdef CENTROID_EN
        ,
        .o_sumx  (w_sumx),
        .o_sumy  (w_sumy)
`endif
    );

    // An empty frame publishes zeros rather than the all-ones min seeds.
    always_ff @(posedge PCLK or negedge Reset_n) begin
        if (!Reset_n) begin
            ObjValid   <= 1'b0;
            XMin       <= '0;
            XMax       <= '0;
            YMin       <= '0;
            YMax       <= '0;
            PixelCount <= '0;
        end else if (r_state == ST_DONE) begin
            ObjValid   <= (w_count >= ADDR_W'(MIN_PIXELS));
            PixelCount <= w_count;
            XMin       <= (w_count == '0) ? '0 : w_xmin;
            XMax       <= (w_count == '0) ? '0 : w_xmax;
            YMin       <= (w_count == '0) ? '0 : w_ymin;
            YMax       <= (w_count == '0) ? '0 : w_ymax;
        end
    end

`ifdef CENTROID_EN
    always_ff @(posedge PCLK or negedge Reset_n) begin
        if (!Reset_n) begin
            SumX <= '0;
            SumY <= '0;
        end else if (r_state == ST_DONE) begin
            SumX <= w_sumx;
            SumY <= w_sumy;
        end
    end
`endif

    assign ReadAddr = r_addr;
    assign Busy     = (r_state == ST_SCAN) || (r_state == ST_DRAIN);
    assign Done     = (r_state == ST_DONE);
endmodule
